branch_target_buffer_fsm: RTL and testbench
===========================================

Name: branch_target_buffer_fsm

Overview:
- 2-bit saturating-counter branch-direction predictor update unit for the branch target buffer (BTB).
- Takes a BTB entry's stored 2-bit prediction plus the resolved branch outcome, and returns the registered updated prediction for write-back to the entry.
- Also flags whether the stored prediction was a misprediction.
- Sits between branch resolution in execute and the BTB prediction array.

Parameters:
- STAT_W, 16, width of the optional statistics counters (used only when BTB_FSM_STATS_EN is defined).

Ports:
- btb_fsm_clk  input  1  single clock; all state updates on rising edge.
- btb_fsm_rst  input  1  reset; synchronous, active-high.
- btb_fsm_branch_taken  input  1  resolved outcome: 1 = taken, 0 = not taken.
- btb_fsm_current_prediction  input  2  stored counter state of the BTB entry being updated.
- btb_fsm_new_prediction  output  2  registered updated counter state.
- btb_fsm_predict_taken  output  1  equals btb_fsm_new_prediction[1].
- btb_fsm_mispredict  output  1  registered; 1 when current_prediction[1] != branch_taken in the sampled cycle.

Behaviour:
- State encoding:
  - 2'b00 strongly not taken (SNT)
  - 2'b01 weakly not taken (WNT)
  - 2'b10 weakly taken (WT)
  - 2'b11 strongly taken (ST)
- Next-state function (combinational on the inputs):
  - taken = 1: 00->01, 01->10, 10->11, 11->11 (saturate high).
  - taken = 0: 11->10, 10->01, 01->00, 00->00 (saturate low).
- Latency: inputs are sampled at a rising edge; new_prediction, predict_taken and mispredict are valid after that edge. Latency is exactly 1 cycle.
- An update occurs every cycle; there is no enable and no handshake. The block is stateless apart from its output registers.
- Output registers hold between edges only; each edge overwrites them from the current inputs.
- The next state depends only on the inputs, never on the previous new_prediction value.
- Reset (btb_fsm_rst = 1 at an edge):
  - new_prediction = 2'b01 (WNT)
  - predict_taken = 0
  - mispredict = 0
  - Reset has priority over any input.
- Reset asserted mid-stream discards that cycle's update. The first edge after reset deasserts resumes normal updates.
- Before the first reset, output values are undefined. No X-propagation guarantee when branch_taken is X.
- Arithmetic: increment and decrement are 2-bit saturating. Wrap-around (11->00 or 00->11) is forbidden.

Optional Feature:
- Macro: BTB_FSM_STATS_EN.
- When defined, adds outputs:
  - btb_fsm_update_count [STAT_W-1:0]: counts every non-reset update cycle.
  - btb_fsm_mispredict_count [STAT_W-1:0]: counts cycles where the sampled prediction mispredicted.
- Both counters:
  - synchronously clear to 0 on btb_fsm_rst;
  - saturate at all-ones and never wrap;
  - update on the same edge as new_prediction.
- When undefined: the ports and logic are absent, and the core behaviour is identical.

Test Plan:
- Reset: assert rst for 2 edges with inputs current=11, taken=1 -> new_prediction=01, predict_taken=0, mispredict=0.
- Saturation and sequence, one cycle per row:
  - current=11, taken=1 -> 11
  - current=11, taken=0 -> 10, mispredict=1
  - current=10, taken=0 -> 01, mispredict=1
  - current=00, taken=0 -> 00, mispredict=0
  - current=00, taken=1 -> 01, mispredict=1
  - current=01, taken=1 -> 10, mispredict=1
  - current=01, taken=0 -> 00, mispredict=0
- Exhaustive: all 8 (current, taken) combinations -> next state matches the table above; predict_taken = new[1]; one-cycle latency confirmed by checking the output only after the edge.
- Mid-stream reset: current=10, taken=1 with rst=1 at that edge -> 01 (not 11); next edge with rst=0 -> 11.
- Hold/overwrite: inputs change between edges (current 00->11, taken 0->1) -> output stays unchanged until the next rising edge, then becomes 11.
- BTB_FSM_STATS_EN: with STAT_W=2, apply 5 mispredicting updates -> mispredict_count saturates at 3, update_count=3; rst -> both 0.

Source files
------------

// File: rtl/branch_target_buffer_fsm.sv
// 2-bit saturating branch-direction counter update for BTB write-back, plus a mispredict flag.
// Latency: 1 cycle, with registered outputs. Backpressure: none, because the block updates every cycle.
// Define BTB_FSM_STATS_EN to add saturating update and mispredict counters of width STAT_W.
module branch_target_buffer_fsm
`ifdef BTB_FSM_STATS_EN
#(
    parameter int STAT_W = 16
)
`endif
(
    input  logic       btb_fsm_clk,
    input  logic       btb_fsm_rst,
    input  logic       btb_fsm_branch_taken,
    input  logic [1:0] btb_fsm_current_prediction,
    output logic [1:0] btb_fsm_new_prediction,
    output logic       btb_fsm_predict_taken,
    output logic       btb_fsm_mispredict
`ifdef BTB_FSM_STATS_EN
    ,
    output logic [STAT_W-1:0] btb_fsm_update_count,
    output logic [STAT_W-1:0] btb_fsm_mispredict_count
`endif
);

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } pred_e;

    pred_e pred_q;
    pred_e cur_pred;
    pred_e next_pred;
    logic  mispredict_q;
    logic  next_mispredict;

    // The next state comes only from the incoming entry state and never from pred_q.
    always_comb begin
        cur_pred        = pred_e'(btb_fsm_current_prediction);
        next_pred       = cur_pred;
        next_mispredict = btb_fsm_current_prediction[1] ^ btb_fsm_branch_taken;
        case (cur_pred)
            SNT:     next_pred = btb_fsm_branch_taken ? WNT : SNT;
            WNT:     next_pred = btb_fsm_branch_taken ? WT  : SNT;
            WT:      next_pred = btb_fsm_branch_taken ? ST  : WNT;
            ST:      next_pred = btb_fsm_branch_taken ? ST  : WT;
            default: next_pred = WNT;
        endcase
    end

    always_ff @(posedge btb_fsm_clk) begin
        if (btb_fsm_rst) begin
            pred_q       <= WNT;
            mispredict_q <= 1'b0;
        end else begin
            pred_q       <= next_pred;
            mispredict_q <= next_mispredict;
        end
    end

    assign btb_fsm_new_prediction = pred_q;
    assign btb_fsm_predict_taken  = pred_q[1];
    assign btb_fsm_mispredict     = mispredict_q;

`ifdef BTB_FSM_STATS_EN
    logic [STAT_W-1:0] update_cnt_q;
    logic [STAT_W-1:0] mispredict_cnt_q;

    always_ff @(posedge btb_fsm_clk) begin
        if (btb_fsm_rst) begin
            update_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            if (update_cnt_q != '1)
                update_cnt_q <= update_cnt_q + STAT_W'(1);
            if (next_mispredict && (mispredict_cnt_q != '1))
                mispredict_cnt_q <= mispredict_cnt_q + STAT_W'(1);
        end
    end

    assign btb_fsm_update_count     = update_cnt_q;
    assign btb_fsm_mispredict_count = mispredict_cnt_q;
`endif

endmodule

// File: tb/tb_branch_target_buffer_fsm.sv
// Scoreboard bench for branch_target_buffer_fsm: expectations are queued at drive time and compared one edge later.
module tb_branch_target_buffer_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       taken;
    logic [1:0] cur;
    logic [1:0] new_pred;
    logic       pred_taken;
    logic       mispred;

    int checks = 0;
    int fails  = 0;

`ifdef BTB_FSM_STATS_EN
    localparam int SW = 2;
    logic [SW-1:0] upd_cnt;
    logic [SW-1:0] mis_cnt;
    int            m_upd = 0;
    int            m_mis = 0;
`endif

    typedef struct {
        string      tag;
        logic [1:0] pred;
        logic       mis;
        int         upd_cnt;
        int         mis_cnt;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

`ifdef BTB_FSM_STATS_EN
    branch_target_buffer_fsm #(.STAT_W(SW)) dut (
`else
    branch_target_buffer_fsm dut (
`endif
        .btb_fsm_clk                (clk),
        .btb_fsm_rst                (rst),
        .btb_fsm_branch_taken       (taken),
        .btb_fsm_current_prediction (cur),
        .btb_fsm_new_prediction     (new_pred),
        .btb_fsm_predict_taken      (pred_taken),
        .btb_fsm_mispredict         (mispred)
`ifdef BTB_FSM_STATS_EN
        ,
        .btb_fsm_update_count       (upd_cnt),
        .btb_fsm_mispredict_count   (mis_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] model_next(input logic [1:0] c, input logic t);
        if (t) return (c == 2'd3) ? 2'd3 : c + 2'd1;
        else   return (c == 2'd0) ? 2'd0 : c - 2'd1;
    endfunction

    // Drive inputs for the coming edge and queue what that edge must produce.
    task automatic drive(input string tag, input logic r, input logic [1:0] c, input logic t);
        exp_t e;
        rst   = r;
        cur   = c;
        taken = t;
        e.tag = tag;
        if (r) begin
            e.pred = 2'b01;
            e.mis  = 1'b0;
        end else begin
            e.pred = model_next(c, t);
            e.mis  = c[1] ^ t;
        end
`ifdef BTB_FSM_STATS_EN
        if (r) begin
            m_upd = 0;
            m_mis = 0;
        end else begin
            if (m_upd < 3) m_upd++;
            if (e.mis && m_mis < 3) m_mis++;
        end
        e.upd_cnt = m_upd;
        e.mis_cnt = m_mis;
`else
        e.upd_cnt = 0;
        e.mis_cnt = 0;
`endif
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        check("sb_depth", sb.size(), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({e.tag, "_pred"}, new_pred, e.pred);
            check({e.tag, "_taken"}, pred_taken, e.pred[1]);
            check({e.tag, "_mis"}, mispred, e.mis);
`ifdef BTB_FSM_STATS_EN
            check({e.tag, "_updcnt"}, upd_cnt, e.upd_cnt);
            check({e.tag, "_miscnt"}, mis_cnt, e.mis_cnt);
`endif
        end
    endtask

    initial begin
        rst   = 1'b1;
        cur   = 2'b11;
        taken = 1'b1;

        drive("rst0", 1'b1, 2'b11, 1'b1); tick();
        drive("rst1", 1'b1, 2'b11, 1'b1); tick();

        drive("seq_11t", 1'b0, 2'b11, 1'b1); tick();
        drive("seq_11n", 1'b0, 2'b11, 1'b0); tick();
        drive("seq_10n", 1'b0, 2'b10, 1'b0); tick();
        drive("seq_00n", 1'b0, 2'b00, 1'b0); tick();
        drive("seq_00t", 1'b0, 2'b00, 1'b1); tick();
        drive("seq_01t", 1'b0, 2'b01, 1'b1); tick();
        drive("seq_01n", 1'b0, 2'b01, 1'b0); tick();

        for (int c = 0; c < 4; c++) begin
            for (int t = 0; t < 2; t++) begin
                drive($sformatf("exh_%0d_%0d", c, t), 1'b0, 2'(c), 1'(t));
                tick();
            end
        end

        drive("mid_rst", 1'b1, 2'b10, 1'b1); tick();
        drive("mid_rel", 1'b0, 2'b10, 1'b1); tick();

        // The output must keep the last edge's value while the inputs change mid-cycle.
        drive("hold_a", 1'b0, 2'b00, 1'b0); tick();
        drive("hold_b", 1'b0, 2'b11, 1'b1);
        #2;
        check("hold_mid_pred", new_pred, 2'b00);
        check("hold_mid_taken", pred_taken, 1'b0);
        tick();

        for (int i = 0; i < 20; i++) begin
            drive($sformatf("rnd%0d", i), ($urandom_range(0, 9) == 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            tick();
        end

`ifdef BTB_FSM_STATS_EN
        drive("st_rst", 1'b1, 2'b00, 1'b0); tick();
        for (int i = 0; i < 5; i++) begin
            drive($sformatf("st_mis%0d", i), 1'b0, 2'b00, 1'b1);
            tick();
        end
        check("st_sat_mis", mis_cnt, 2'd3);
        check("st_sat_upd", upd_cnt, 2'd3);
        drive("st_clr", 1'b1, 2'b11, 1'b0); tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
